ramp_bist: RTL and testbench

Synthesizable RAM test sequencer: the initiator side of the `ramp` single-port RAM interface. On `start` it writes a seed-derived pattern to every address, reads it back and compares, then repeats with the inverted pattern. It reports pass/fail, the error count and the first failing address. It sits between a control/status block and one `ramp` instance. It replaces bench-only write/read loops with hardware usable in-system.

---
 rtl/ramp_pkg.sv | 37 +++
 rtl/ramp_bist_chk.sv | 96 +++++++++
 rtl/ramp_bist.sv | 152 +++++++++++++++
 tb/tb_ramp_bist.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp RAM interface and its BIST sequencer.
package ramp_pkg;

  // Default geometry shared with the ramp RAM: 2**7 words of 2**4 bits.
  localparam int unsigned RAMP_R_DEF = 7;
  localparam int unsigned RAMP_W_DEF = 4;

  // Phase index: which pattern polarity a WR/RD phase uses.
  localparam logic PHASE_TRUE = 1'b0;
  localparam logic PHASE_INV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR0   = 3'd1,
    ST_RD0   = 3'd2,
    ST_WR1   = 3'd3,
    ST_RD1   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } ramp_bist_state_t;

  // Pattern polarity used by a given state.
  function automatic logic phase_of(input ramp_bist_state_t s);
    return (s == ST_WR1 || s == ST_RD1) ? PHASE_INV : PHASE_TRUE;
  endfunction

  // States that write the RAM.
  function automatic logic is_wr_state(input ramp_bist_state_t s);
    return (s == ST_WR0 || s == ST_WR1);
  endfunction

  // States that issue reads to the RAM.
  function automatic logic is_rd_state(input ramp_bist_state_t s);
    return (s == ST_RD0 || s == ST_RD1);
  endfunction

endpackage

// File: rtl/ramp_bist_chk.sv
// Read-compare unit: delays each read issue by the RAM latency, compares the
// returned word and captures the error count and the first failing location.
module ramp_bist_chk
  import ramp_pkg::*;
#(
  parameter int unsigned R      = RAMP_R_DEF,
  parameter int unsigned DW     = 2**RAMP_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          iss_vld_i,
  input  logic [R-1:0]  iss_addr_i,
  input  logic          iss_phase_i,
  input  logic [DW-1:0] iss_exp_i,
  input  logic [DW-1:0] mem_dout_i,
  output logic [R+1:0]  err_count_o,
  output logic [R-1:0]  fail_addr_o,
  output logic          fail_pass_o
);

  localparam int unsigned CW   = R + 2;
  localparam int unsigned LAST = RD_LAT - 1;

  logic          vld_q   [RD_LAT];
  logic [R-1:0]  addr_q  [RD_LAT];
  logic          phase_q [RD_LAT];
  logic [DW-1:0] exp_q   [RD_LAT];

  logic [CW-1:0] err_q, err_d;
  logic [R-1:0]  faddr_q, faddr_d;
  logic          fpass_q, fpass_d;
  logic          hit;

  // Issue pipeline: the last stage lines up with the word the RAM returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i]   <= 1'b0;
        addr_q[i]  <= '0;
        phase_q[i] <= 1'b0;
        exp_q[i]   <= '0;
      end
    end else begin
      vld_q[0]   <= iss_vld_i;
      addr_q[0]  <= iss_addr_i;
      phase_q[0] <= iss_phase_i;
      exp_q[0]   <= iss_exp_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        phase_q[i] <= phase_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  assign hit = vld_q[LAST] && (mem_dout_i != exp_q[LAST]);

  // Error counting; the failing location is latched only on the first error.
  always_comb begin
    err_d   = err_q;
    faddr_d = faddr_q;
    fpass_d = fpass_q;
    if (clr_i) begin
      err_d   = '0;
      faddr_d = '0;
      fpass_d = 1'b0;
    end else if (hit) begin
      err_d = err_q + CW'(1);
      if (err_q == '0) begin
        faddr_d = addr_q[LAST];
        fpass_d = phase_q[LAST];
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      faddr_q <= '0;
      fpass_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fpass_q <= fpass_d;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = faddr_q;
  assign fail_pass_o = fpass_q;

endmodule

// File: rtl/ramp_bist.sv
// RAM test sequencer: writes seed^addr to every word, reads it back, then
// repeats with the inverted pattern, reporting pass/fail and first failure.
module ramp_bist
  import ramp_pkg::*;
#(
  parameter int unsigned R      = RAMP_R_DEF,
  parameter int unsigned W      = RAMP_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2**W-1:0]   seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [R+1:0]      err_count,
  output logic [R-1:0]      fail_addr,
  output logic              fail_pass,
  output logic              mem_wr_rd,
  output logic [R-1:0]      mem_addr,
  output logic [2**W-1:0]   mem_din,
  input  logic [2**W-1:0]   mem_dout
);

  localparam int unsigned DW = 2**W;

  ramp_bist_state_t state_q, state_d;
  logic [R-1:0]     addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [DW-1:0]    din_q, din_d;
  logic [DW-1:0]    seed_q, seed_d;
  logic [2:0]       drain_q, drain_d;
  logic             clr;
  logic             last_addr;
  logic             iss_vld;
  logic             iss_phase;
  logic [DW-1:0]    iss_exp;

  // Test pattern: seed XOR zero-extended address, optionally inverted.
  function automatic logic [DW-1:0] pat(input logic [DW-1:0] s,
                                        input logic [R-1:0]  a,
                                        input logic          inv);
    logic [DW-1:0] p;
    p = s ^ DW'(a);
    return inv ? ~p : p;
  endfunction

  assign last_addr = (addr_q == '1);

  // Next-state, address sweep and write-data generation. The mem_* outputs
  // are registered, so they are computed from the next state and address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    din_d   = din_q;
    seed_d  = seed_q;
    drain_d = drain_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WR0;
          seed_d  = seed;
          addr_d  = '0;
          clr     = 1'b1;
        end
      end
      ST_WR0: begin
        addr_d = addr_q + R'(1);
        if (last_addr) state_d = ST_RD0;
      end
      ST_RD0: begin
        addr_d = addr_q + R'(1);
        if (last_addr) state_d = ST_WR1;
      end
      ST_WR1: begin
        addr_d = addr_q + R'(1);
        if (last_addr) state_d = ST_RD1;
      end
      ST_RD1: begin
        addr_d = addr_q + R'(1);
        if (last_addr) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == 3'(RD_LAT - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (is_wr_state(state_d)) begin
      wr_d  = 1'b1;
      din_d = pat(seed_d, addr_d, phase_of(state_d));
    end
  end

  // Sequencer state and RAM-side output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      seed_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      seed_q  <= seed_d;
      drain_q <= drain_d;
    end
  end

  // Read issue for the word currently addressed on the RAM bus.
  always_comb begin
    iss_vld   = is_rd_state(state_q);
    iss_phase = phase_of(state_q);
    iss_exp   = pat(seed_q, addr_q, iss_phase);
  end

  ramp_bist_chk #(
    .R      (R),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .iss_vld_i   (iss_vld),
    .iss_addr_i  (addr_q),
    .iss_phase_i (iss_phase),
    .iss_exp_i   (iss_exp),
    .mem_dout_i  (mem_dout),
    .err_count_o (err_count),
    .fail_addr_o (fail_addr),
    .fail_pass_o (fail_pass)
  );

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_count == '0);
  assign mem_wr_rd = wr_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;

endmodule

// File: tb/tb_ramp_bist.sv
// Scoreboard bench for ramp_bist: two instances (RD_LAT 1 and 3) each drive
// their own RAM model with injectable stuck-at faults.
module tb_ramp_bist;

  localparam int R  = 7;
  localparam int W  = 4;
  localparam int N  = 2**R;
  localparam int DW = 2**W;

  typedef struct {
    int k;
    int err;
    int faddr;
    int fpass;
    int pass_b;
  } exp_t;

  logic clk, rst, start;
  logic [DW-1:0] seed;

  logic busy1, done1, pass1, fpass1, wr1;
  logic [R+1:0] err1;
  logic [R-1:0] faddr1, addr1;
  logic [DW-1:0] din1, dout1;
  logic busy3, done3, pass3, fpass3, wr3;
  logic [R+1:0] err3;
  logic [R-1:0] faddr3, addr3;
  logic [DW-1:0] din3, dout3;

  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] mem3 [N];
  logic [DW-1:0] sa0  [N];
  logic [DW-1:0] sa1  [N];
  logic [DW-1:0] d1, d3a, d3b, d3c;

  exp_t q1[$];
  exp_t q3[$];
  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int blen1 = 0, blen3 = 0;
  logic dprev1 = 1'b0, dprev3 = 1'b0;

  ramp_bist #(.R(R), .W(W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_addr(faddr1), .fail_pass(fpass1), .mem_wr_rd(wr1),
    .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1)
  );

  ramp_bist #(.R(R), .W(W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_addr(faddr3), .fail_pass(fpass3), .mem_wr_rd(wr3),
    .mem_addr(addr3), .mem_din(din3), .mem_dout(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input int a);
    return (v & ~sa0[a]) | sa1[a];
  endfunction

  // RAM models: stuck-at faults act on the read path.
  always @(posedge clk) begin
    if (wr1) mem1[addr1] <= din1;
    d1 <= rd_fault(mem1[addr1], int'(addr1));
    if (wr3) mem3[addr3] <= din3;
    d3a <= rd_fault(mem3[addr3], int'(addr3));
    d3b <= d3a;
    d3c <= d3b;
  end
  assign dout1 = d1;
  assign dout3 = d3c;

  task automatic cmp(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Reference: what a correct BIST must report for this seed and fault map.
  function automatic exp_t model(input logic [DW-1:0] s, input int k);
    exp_t e;
    logic [DW-1:0] w, r;
    e.k = k; e.err = 0; e.faddr = 0; e.fpass = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < N; a++) begin
        w = s ^ DW'(a);
        if (p == 1) w = ~w;
        r = (w & ~sa0[a]) | sa1[a];
        if (r != w) begin
          if (e.err == 0) begin e.faddr = a; e.fpass = p; end
          e.err++;
        end
      end
    end
    e.pass_b = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check_run(input string tag, input int lat, input exp_t e, input int c,
                           input int bl, input int err, input int fa, input int fp, input int ps);
    cmp({tag, "_done_latency"}, c - e.k, 4*N + lat + 1);
    cmp({tag, "_busy_cycles"}, bl, 4*N + lat);
    cmp({tag, "_err_count"}, err, e.err);
    cmp({tag, "_fail_addr"}, fa, e.faddr);
    cmp({tag, "_fail_pass"}, fp, e.fpass);
    cmp({tag, "_pass"}, ps, e.pass_b);
  endtask

  // Monitor, RD_LAT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) blen1 = 0;
    else begin
      if (busy1) blen1++;
      if (done1 && !dprev1) begin
        if (q1.size() == 0) cmp("lat1_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          check_run("lat1", 1, e, cyc, blen1, int'(err1), int'(faddr1), int'(fpass1), int'(pass1));
        end
        blen1 = 0;
      end
    end
    dprev1 = done1;
  end

  // Monitor, RD_LAT=3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) blen3 = 0;
    else begin
      if (busy3) blen3++;
      if (done3 && !dprev3) begin
        if (q3.size() == 0) cmp("lat3_unexpected_done", 1, 0);
        else begin
          e = q3.pop_front();
          check_run("lat3", 3, e, cyc, blen3, int'(err3), int'(faddr3), int'(fpass3), int'(pass3));
        end
        blen3 = 0;
      end
    end
    dprev3 = done3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    cmp({tag, "_busy"}, int'(busy1) + int'(busy3), 0);
    cmp({tag, "_done"}, int'(done1) + int'(done3), 0);
    cmp({tag, "_pass"}, int'(pass1) + int'(pass3), 0);
    cmp({tag, "_err"}, int'(err1) + int'(err3), 0);
    cmp({tag, "_faddr"}, int'(faddr1) + int'(faddr3), 0);
    cmp({tag, "_fpass"}, int'(fpass1) + int'(fpass3), 0);
    cmp({tag, "_wr"}, int'(wr1) + int'(wr3), 0);
    cmp({tag, "_addr"}, int'(addr1) + int'(addr3), 0);
    cmp({tag, "_din"}, int'(din1) + int'(din3), 0);
  endtask

  // Pulse start with a seed; queue the expected result; check first write.
  task automatic run_start(input logic [DW-1:0] s);
    start = 1'b1;
    seed  = s;
    q1.push_back(model(s, cyc));
    q3.push_back(model(s, cyc));
    step();
    start = 1'b0;
    cmp("first_busy", int'(busy1) + int'(busy3), 2);
    cmp("first_wr", int'(wr1) + int'(wr3), 2);
    cmp("first_addr", int'(addr1) + int'(addr3), 0);
    cmp("first_din1", int'(din1), int'(s));
    cmp("first_din3", int'(din3), int'(s));
    cmp("first_done_clear", int'(done1) + int'(done3), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(done1 && done3 && q1.size() == 0 && q3.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    cmp("run_completed_in_budget", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int k0, n;
    logic [DW-1:0] s;
    rst = 1'b0; start = 1'b0; seed = '0;
    clear_faults();
    #1 rst = 1'b1;
    #1 chk_reset_vals("reset");
    step(); step();
    rst = 1'b0;
    step();

    // Fault-free run
    run_start(16'hA5A5);
    wait_idle(2000);
    step(); step();
    cmp("done_held", int'(done1) + int'(done3), 2);

    // Stuck-at-0, bit0 of address 5: only the inverted pass sees it
    sa0[5] = 16'h0001;
    run_start(16'hA5A5);
    wait_idle(2000);

    // Stuck-at-1, bit0 of addresses 4 and 6, seed 0
    clear_faults();
    sa1[4] = 16'h0001;
    sa1[6] = 16'h0001;
    run_start(16'h0000);
    wait_idle(2000);

    // start pulsed during a run is ignored
    clear_faults();
    k0 = cyc;
    run_start(16'h3C3C);
    while (cyc < k0 + 100) step();
    start = 1'b1; seed = 16'hFFFF;
    step();
    start = 1'b0;
    wait_idle(2000);

    // Asynchronous reset during WR0 at address 40
    k0 = cyc;
    run_start(16'h1234);
    n = 0;
    while (!(wr1 && addr1 == 7'd40) && n < 200) begin step(); n++; end
    cmp("addr40_reached_at", cyc - k0, 41);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrun_reset");
    q1.delete();
    q3.delete();
    step(); step();
    rst = 1'b0;
    step();
    run_start(16'h1234);
    wait_idle(2000);

    // start held through DONE: immediate restart with the new seed
    start = 1'b1;
    seed  = 16'hA5A5;
    q1.push_back(model(16'hA5A5, cyc));
    q3.push_back(model(16'hA5A5, cyc));
    step();
    seed = 16'h0001;
    fork
      begin : w1
        int m;
        m = 0;
        while (!done1 && m < 2000) begin @(negedge clk); m++; end
        cmp("held_restart_done1", int'(done1), 1);
        q1.push_back(model(16'h0001, cyc));
      end
      begin : w3
        int m;
        m = 0;
        while (!done3 && m < 2000) begin @(negedge clk); m++; end
        cmp("held_restart_done3", int'(done3), 1);
        q3.push_back(model(16'h0001, cyc));
      end
    join
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(2000);

    // Randomised runs: random seed, random stuck bits, random ignored starts
    for (int it = 0; it < 6; it++) begin
      clear_faults();
      n = $urandom_range(0, 3);
      for (int f = 0; f < n; f++) begin
        int a, b;
        a = $urandom_range(0, N-1);
        b = $urandom_range(0, DW-1);
        if ($urandom_range(0, 1) == 1) sa0[a][b] = 1'b1;
        else sa1[a][b] = 1'b1;
      end
      s = DW'($urandom);
      run_start(s);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(10, 400);
        for (int j = 0; j < n; j++) step();
        start = 1'b1; seed = ~s;
        step();
        start = 1'b0;
      end
      wait_idle(2000);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) step();
      cmp("rand_done_held", int'(done1) + int'(done3), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
